// File: rtl/flow_pkg.sv
// Shared constants and FSM encoding for the uart_tx flow-control arbiter.
package flow_pkg;

    localparam logic [7:0] XOFF_BYTE = 8'h13;
    localparam logic [7:0] XON_BYTE  = 8'h11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STROBE    = 2'd1,
        ST_WAIT_ACT  = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_flow_arbiter_if.sv
// Byte-stream handshake between sample2uart, the arbiter and uart_tx.
interface uart_tx_flow_arbiter_if;

    logic       data_valid;
    logic [7:0] data_byte;
    logic       data_busy;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;

    modport master (
        input  data_valid, data_byte, tx_active,
        output data_busy, tx_dv, tx_byte
    );

    modport slave (
        output data_valid, data_byte, tx_active,
        input  data_busy, tx_dv, tx_byte
    );

endinterface

// File: rtl/flow_level_monitor.sv
// FIFO fill-level hysteresis: decides XON/XOFF and holds the single pending control byte.
module flow_level_monitor
    import flow_pkg::*;
#(
    parameter int unsigned COUNT_W   = 11,
    parameter int unsigned HIGH_MARK = 768,
    parameter int unsigned LOW_MARK  = 256,
    parameter logic [7:0]  XOFF_VAL  = XOFF_BYTE,
    parameter logic [7:0]  XON_VAL   = XON_BYTE
) (
    input  logic               in_clk,
    input  logic               in_reset,
    input  logic               in_flow_en,
    input  logic [COUNT_W-1:0] in_fifo_count,
    input  logic               take_i,
    output logic               pend_valid_o,
    output logic [7:0]         pend_byte_o,
    output logic               xoff_state_o
);

    localparam logic [COUNT_W-1:0] HIGH_C = COUNT_W'(HIGH_MARK);
    localparam logic [COUNT_W-1:0] LOW_C  = COUNT_W'(LOW_MARK);

    logic       xoff_q, xoff_d;
    logic       flow_en_q;
    logic       pend_valid_q, pend_valid_d;
    logic [7:0] pend_byte_q, pend_byte_d;
    logic [7:0] last_q, last_d;
    logic       dec_valid;
    logic [7:0] dec_byte;

    always_comb begin
        xoff_d    = xoff_q;
        dec_valid = 1'b0;
        dec_byte  = XON_VAL;
        if (flow_en_q && !in_flow_en && xoff_q) begin
            xoff_d    = 1'b0;
            dec_valid = 1'b1;
            dec_byte  = XON_VAL;
        end else if (in_flow_en) begin
            if (!xoff_q && in_fifo_count >= HIGH_C) begin
                xoff_d    = 1'b1;
                dec_valid = 1'b1;
                dec_byte  = XOFF_VAL;
            end else if (xoff_q && in_fifo_count <= LOW_C) begin
                xoff_d    = 1'b0;
                dec_valid = 1'b1;
                dec_byte  = XON_VAL;
            end
        end

        // A byte taken this cycle already counts as sent for the cancel compare.
        last_d       = take_i ? pend_byte_q : last_q;
        pend_valid_d = pend_valid_q & ~take_i;
        pend_byte_d  = pend_byte_q;
        if (dec_valid) begin
            pend_byte_d  = dec_byte;
            pend_valid_d = (dec_byte != last_d);
        end
    end

    // The host starts out in the XON condition, so an XON needs no resend.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            xoff_q       <= 1'b0;
            flow_en_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_byte_q  <= 8'h00;
            last_q       <= XON_VAL;
        end else begin
            xoff_q       <= xoff_d;
            flow_en_q    <= in_flow_en;
            pend_valid_q <= pend_valid_d;
            pend_byte_q  <= pend_byte_d;
            last_q       <= last_d;
        end
    end

    assign pend_valid_o = pend_valid_q;
    assign pend_byte_o  = pend_byte_q;
    assign xoff_state_o = xoff_q;

endmodule

// File: rtl/uart_tx_flow_arbiter.sv
// Shares uart_tx between the sample2uart data stream and XON/XOFF flow-control bytes.
//   state      | meaning
//   IDLE       | accept data pulse or pending control byte
//   STROBE     | one-cycle out_tx_dv to uart_tx
//   WAIT_ACT   | wait for uart_tx to go active
//   WAIT_IDLE  | wait for uart_tx to finish the byte
module uart_tx_flow_arbiter
    import flow_pkg::*;
#(
    parameter int unsigned COUNT_W   = 11,
    parameter int unsigned HIGH_MARK = 768,
    parameter int unsigned LOW_MARK  = 256,
    parameter logic [7:0]  XOFF_VAL  = XOFF_BYTE,
    parameter logic [7:0]  XON_VAL   = XON_BYTE
) (
    input  logic                   in_clk,
    input  logic                   in_reset,
    input  logic                   in_flow_en,
    input  logic [COUNT_W-1:0]     in_fifo_count,
    uart_tx_flow_arbiter_if.master tx_if,
    output logic                   out_xoff_state,
    output logic [7:0]             out_ctrl_count
);

    arb_state_e state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       is_ctrl_q, is_ctrl_d;
    logic [7:0] ctrl_cnt_q, ctrl_cnt_d;
    logic       pend_valid;
    logic [7:0] pend_byte;
    logic       busy;
    logic       accept;
    logic       take;

    flow_level_monitor #(
        .COUNT_W   (COUNT_W),
        .HIGH_MARK (HIGH_MARK),
        .LOW_MARK  (LOW_MARK),
        .XOFF_VAL  (XOFF_VAL),
        .XON_VAL   (XON_VAL)
    ) u_mon (
        .in_clk        (in_clk),
        .in_reset      (in_reset),
        .in_flow_en    (in_flow_en),
        .in_fifo_count (in_fifo_count),
        .take_i        (take),
        .pend_valid_o  (pend_valid),
        .pend_byte_o   (pend_byte),
        .xoff_state_o  (out_xoff_state)
    );

    // A pending control byte raises busy, so data can only win in the cycle it appears.
    assign busy   = in_reset | (state_q != ST_IDLE) | tx_if.tx_active | pend_valid;
    assign accept = tx_if.data_valid & ~busy;
    assign take   = (state_q == ST_IDLE) & pend_valid & ~tx_if.tx_active;

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        is_ctrl_d  = is_ctrl_q;
        ctrl_cnt_d = ctrl_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    byte_d    = tx_if.data_byte;
                    is_ctrl_d = 1'b0;
                    state_d   = ST_STROBE;
                end else if (take) begin
                    byte_d    = pend_byte;
                    is_ctrl_d = 1'b1;
                    state_d   = ST_STROBE;
                end
            end
            ST_STROBE:   state_d = ST_WAIT_ACT;
            ST_WAIT_ACT: if (tx_if.tx_active) state_d = ST_WAIT_IDLE;
            ST_WAIT_IDLE: begin
                if (!tx_if.tx_active) begin
                    state_d = ST_IDLE;
                    if (is_ctrl_q && ctrl_cnt_q != 8'hFF) ctrl_cnt_d = ctrl_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_q    <= ST_IDLE;
            byte_q     <= 8'h00;
            is_ctrl_q  <= 1'b0;
            ctrl_cnt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            is_ctrl_q  <= is_ctrl_d;
            ctrl_cnt_q <= ctrl_cnt_d;
        end
    end

    assign tx_if.data_busy = busy;
    assign tx_if.tx_dv     = (state_q == ST_STROBE);
    assign tx_if.tx_byte   = byte_q;
    assign out_ctrl_count  = ctrl_cnt_q;

endmodule

// File: tb/tb_uart_tx_flow_arbiter.sv
// Directed bench for uart_tx_flow_arbiter with a small behavioural uart_tx responder.
module tb_uart_tx_flow_arbiter;

    localparam int TX_LEN = 10;

    logic        clk;
    logic        rst;
    logic        flow_en;
    logic [10:0] count;
    logic        xoff;
    logic [7:0]  ctrl_cnt;
    logic [7:0]  sent_q[$];
    int          n_total;
    int          n_bad;

    uart_tx_flow_arbiter_if ifc();

    uart_tx_flow_arbiter dut (
        .in_clk         (clk),
        .in_reset       (rst),
        .in_flow_en     (flow_en),
        .in_fifo_count  (count),
        .tx_if          (ifc),
        .out_xoff_state (xoff),
        .out_ctrl_count (ctrl_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_active(input logic lvl, input string tag);
        int n;
        n = 0;
        while (ifc.tx_active !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, ifc.tx_active}, {31'd0, lvl});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // uart_tx model: logs each strobed byte, goes active next cycle for TX_LEN cycles.
    initial begin
        ifc.tx_active = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.tx_dv === 1'b1) begin
                sent_q.push_back(ifc.tx_byte);
                @(posedge clk);
                #1 ifc.tx_active = 1'b1;
                repeat (TX_LEN) @(posedge clk);
                #1 ifc.tx_active = 1'b0;
            end
        end
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        flow_en = 1'b1;
        count   = 11'd0;
        ifc.data_valid = 1'b0;
        ifc.data_byte  = 8'h00;
        idle(2);
        chk("rst_dv",   {31'd0, ifc.tx_dv}, 0);
        chk("rst_byte", {24'd0, ifc.tx_byte}, 0);
        chk("rst_busy", {31'd0, ifc.data_busy}, 1);
        chk("rst_xoff", {31'd0, xoff}, 0);
        chk("rst_cnt",  {24'd0, ctrl_cnt}, 0);
        rst = 1'b0;
        idle(1);
        chk("busy_after_rst", {31'd0, ifc.data_busy}, 0);

        // 1: ramp to 800, XOFF at exactly 768
        for (int c = 0; c <= 800; c++) begin
            count = 11'(c);
            @(negedge clk);
            if (c == 767) chk("xoff_at_767", {31'd0, xoff}, 0);
            if (c == 768) chk("xoff_at_768", {31'd0, xoff}, 1);
        end
        idle(40);
        chk("t1_nsent", sent_q.size(), 1);
        chk("t1_byte",  {24'd0, sent_q[0]}, 32'h13);
        chk("t1_cnt",   {24'd0, ctrl_cnt}, 1);

        // 2: fall to 257 (nothing), then 256 -> XON
        for (int c = 800; c >= 257; c--) begin
            count = 11'(c);
            @(negedge clk);
        end
        idle(20);
        chk("t2_nsent_257", sent_q.size(), 1);
        chk("t2_xoff_257",  {31'd0, xoff}, 1);
        count = 11'd256;
        idle(1);
        chk("t2_xoff_256", {31'd0, xoff}, 0);
        idle(40);
        chk("t2_nsent", sent_q.size(), 2);
        chk("t2_byte",  {24'd0, sent_q[1]}, 32'h11);
        chk("t2_cnt",   {24'd0, ctrl_cnt}, 2);

        // 3: data pulse in the cycle XOFF becomes pending -> data first
        chk("t3_busy_pre", {31'd0, ifc.data_busy}, 0);
        count = 11'd768;
        ifc.data_valid = 1'b1;
        ifc.data_byte  = 8'hA5;
        idle(1);
        ifc.data_valid = 1'b0;
        chk("t3_dv_lat", {31'd0, ifc.tx_dv}, 1);
        chk("t3_byte",   {24'd0, ifc.tx_byte}, 32'hA5);
        chk("t3_xoff",   {31'd0, xoff}, 1);
        idle(40);
        chk("t3_nsent", sent_q.size(), 4);
        chk("t3_first", {24'd0, sent_q[2]}, 32'hA5);
        chk("t3_then",  {24'd0, sent_q[3]}, 32'h13);
        chk("t3_cnt",   {24'd0, ctrl_cnt}, 3);

        // 4: back to XON, then 770->250 while tx busy; dropped pulse while busy
        count = 11'd256;
        idle(40);
        chk("t4_xon_pre", {24'd0, sent_q[4]}, 32'h11);
        ifc.data_valid = 1'b1;
        ifc.data_byte  = 8'h5A;
        idle(1);
        ifc.data_valid = 1'b0;
        wait_active(1'b1, "t4_act");
        chk("t4_busy", {31'd0, ifc.data_busy}, 1);
        ifc.data_valid = 1'b1;
        ifc.data_byte  = 8'hEE;
        idle(1);
        ifc.data_valid = 1'b0;
        count = 11'd770;
        idle(1);
        chk("t4_xoff_770", {31'd0, xoff}, 1);
        count = 11'd250;
        idle(1);
        chk("t4_xoff_250", {31'd0, xoff}, 0);
        idle(40);
        chk("t4_nsent", sent_q.size(), 6);
        chk("t4_last",  {24'd0, sent_q[5]}, 32'h5A);
        chk("t4_cnt",   {24'd0, ctrl_cnt}, 4);
        chk("t4_nopend", {31'd0, ifc.data_busy}, 0);

        // 5: XOFF, then disable flow -> XON; high count while disabled sends nothing
        count = 11'd900;
        idle(40);
        flow_en = 1'b0;
        idle(1);
        chk("t5_xoff_dis", {31'd0, xoff}, 0);
        idle(40);
        chk("t5_nsent", sent_q.size(), 8);
        chk("t5_xoff_b", {24'd0, sent_q[6]}, 32'h13);
        chk("t5_xon_b",  {24'd0, sent_q[7]}, 32'h11);
        chk("t5_cnt",    {24'd0, ctrl_cnt}, 6);
        idle(40);
        chk("t5_quiet", sent_q.size(), 8);
        count = 11'd100;
        idle(1);
        flow_en = 1'b1;
        idle(40);
        chk("t5_reen", sent_q.size(), 8);

        // saturation: 260 more control bytes on top of 6
        for (int i = 0; i < 130; i++) begin
            count = 11'd900;
            idle(20);
            count = 11'd100;
            idle(20);
        end
        chk("sat_nsent", sent_q.size(), 268);
        chk("sat_cnt",   {24'd0, ctrl_cnt}, 255);

        // 6: reset during WAIT_IDLE, then data after release
        ifc.data_valid = 1'b1;
        ifc.data_byte  = 8'h3C;
        idle(1);
        ifc.data_valid = 1'b0;
        wait_active(1'b1, "t6_act");
        idle(1);
        rst = 1'b1;
        #1;
        chk("t6_dv",   {31'd0, ifc.tx_dv}, 0);
        chk("t6_byte", {24'd0, ifc.tx_byte}, 0);
        chk("t6_busy", {31'd0, ifc.data_busy}, 1);
        chk("t6_xoff", {31'd0, xoff}, 0);
        chk("t6_cnt",  {24'd0, ctrl_cnt}, 0);
        idle(1);
        rst = 1'b0;
        wait_active(1'b0, "t6_idle");
        ifc.data_valid = 1'b1;
        ifc.data_byte  = 8'hC3;
        idle(1);
        ifc.data_valid = 1'b0;
        chk("t6_post_dv",   {31'd0, ifc.tx_dv}, 1);
        chk("t6_post_byte", {24'd0, ifc.tx_byte}, 32'hC3);
        idle(20);
        chk("t6_nsent", sent_q.size(), 270);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
